// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: mode encoding, FSM state type and the
// helper that picks sample/shift strobes out of synchronised sclk edges.
package spi_pkg;

   typedef enum logic [1:0] {
      MODE0 = 2'b00,
      MODE1 = 2'b01,
      MODE2 = 2'b10,
      MODE3 = 2'b11
   } spi_mode_e;

   typedef enum logic [1:0] {
      WAIT_IDLE,
      IDLE,
      ACTIVE
   } spi_state_e;

   function automatic logic mode_cpol(input spi_mode_e mode);
      return mode[1];
   endfunction

   function automatic logic mode_cpha(input spi_mode_e mode);
      return mode[0];
   endfunction

   // Returns the sample strobe when want_sample is set, otherwise the shift strobe.
   function automatic logic sel_edge(input logic cpol, input logic cpha,
                                     input logic want_sample,
                                     input logic rise, input logic fall);
      logic leading;
      logic trailing;
      leading  = cpol ? fall : rise;
      trailing = cpol ? rise : fall;
      if (want_sample)
         return cpha ? trailing : leading;
      else
         return cpha ? leading : trailing;
   endfunction

endpackage

// File: rtl/spi_target_if.sv
// Fabric-side bundle of the SPI target: buffered transmit handshake, receive
// strobe and error strobes.
interface spi_target_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             tx_underrun;
   logic             cs_abort;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, rx_data, rx_valid, tx_underrun, cs_abort
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, rx_data, rx_valid, tx_underrun, cs_abort
   );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous SPI pin, with one-cycle rise and
// fall strobes taken against a further delayed copy.
module spi_sync_edge #(
   parameter int STAGES    = 2,
   parameter bit RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain <= {STAGES{RESET_VAL}};
         prev  <= RESET_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         prev  <= chain[STAGES-1];
      end
   end

   assign rise = chain[STAGES-1] & ~prev;
   assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_target.sv
// SPI target running entirely in the clk domain: pins are oversampled, words are
// shifted on synchronised sclk edges and handed to the fabric via spi_target_if.
module spi_target
   import spi_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter bit CPOL        = 1'b0,
   parameter bit CPHA        = 1'b0,
   parameter bit MSB_FIRST   = 1'b1,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         spi_sclk,
   input  logic         spi_cs_n,
   input  logic         spi_rx,
   output logic         spi_tx,
   output logic         spi_tx_en,
   spi_target_if.slave  fab
);

   localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int CW    = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   spi_state_e       state;
   spi_state_e       state_next;
   logic             sclk_rise, sclk_fall;
   logic             cs_rise, cs_fall;
   logic [NSYNC-1:0] rx_pipe;
   logic             rx_bit;
   logic             sample_stb, shift_stb, deselect, load_pt;
   logic [CW-1:0]    bit_count;
   logic [WIDTH-1:0] tx_shift, rx_shift, rx_next, hold_reg, rx_data_q;
   logic             hold_full, rx_valid_q, underrun_q, abort_q;

   // sclk resets to its idle level; cs_n resets low so the FSM always waits for
   // a visible deselect before it trusts a select.
   spi_sync_edge #(.STAGES(NSYNC), .RESET_VAL(CPOL)) u_sclk_sync (
      .clk   (clk),
      .reset (reset),
      .din   (spi_sclk),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_sync_edge #(.STAGES(NSYNC), .RESET_VAL(1'b0)) u_cs_sync (
      .clk   (clk),
      .reset (reset),
      .din   (spi_cs_n),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   // MOSI goes through the same depth as sclk so data lines up with its edge strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rx_pipe <= '0;
      else
         rx_pipe <= {rx_pipe[NSYNC-2:0], spi_rx};
   end

   assign rx_bit = rx_pipe[NSYNC-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= WAIT_IDLE;
      else
         state <= state_next;
   end

   // Next state plus the per-cycle strobes derived from the state and sclk edges.
   always_comb begin
      state_next = state;
      sample_stb = 1'b0;
      shift_stb  = 1'b0;
      deselect   = 1'b0;
      load_pt    = 1'b0;
      case (state)
         WAIT_IDLE: if (cs_rise) state_next = IDLE;
         IDLE: begin
            if (cs_fall) begin
               state_next = ACTIVE;
               load_pt    = !CPHA;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_next = IDLE;
               deselect   = 1'b1;
            end else begin
               sample_stb = sel_edge(CPOL, CPHA, 1'b1, sclk_rise, sclk_fall);
               shift_stb  = sel_edge(CPOL, CPHA, 1'b0, sclk_rise, sclk_fall);
               load_pt    = shift_stb && (bit_count == '0);
            end
         end
         default: state_next = WAIT_IDLE;
      endcase
   end

   assign rx_next = MSB_FIRST ? {rx_shift[WIDTH-2:0], rx_bit}
                              : {rx_bit, rx_shift[WIDTH-1:1]};

   // Holding register: a write in the same cycle as an empty load still lands
   // here, so the underrunning word is lost but the new data serves the next one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_reg  <= '0;
         hold_full <= 1'b0;
      end else if (fab.tx_valid && !hold_full) begin
         hold_reg  <= fab.tx_data;
         hold_full <= 1'b1;
      end else if (load_pt && hold_full) begin
         hold_full <= 1'b0;
      end
   end

   // Shift registers, bit counter and the one-cycle fabric strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_shift   <= '0;
         rx_shift   <= '0;
         bit_count  <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;
         abort_q    <= 1'b0;
         if (deselect) begin
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_count <= '0;
            abort_q   <= (bit_count != '0);
         end else begin
            if (load_pt) begin
               tx_shift   <= hold_full ? hold_reg : '0;
               underrun_q <= !hold_full;
            end else if (shift_stb) begin
               tx_shift <= MSB_FIRST ? {tx_shift[WIDTH-2:0], 1'b0}
                                     : {1'b0, tx_shift[WIDTH-1:1]};
            end
            if (sample_stb) begin
               rx_shift <= rx_next;
               if (bit_count == LAST_BIT) begin
                  bit_count  <= '0;
                  rx_data_q  <= rx_next;
                  rx_valid_q <= 1'b1;
               end else begin
                  bit_count <= bit_count + CW'(1);
               end
            end
         end
      end
   end

   assign spi_tx          = MSB_FIRST ? tx_shift[WIDTH-1] : tx_shift[0];
   assign spi_tx_en       = !spi_cs_n;
   assign fab.tx_ready    = !hold_full;
   assign fab.rx_data     = rx_data_q;
   assign fab.rx_valid    = rx_valid_q;
   assign fab.tx_underrun = underrun_q;
   assign fab.cs_abort    = abort_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a mode-0 8-bit MSB-first instance and a mode-3 16-bit
// LSB-first instance driven by bit-banged controllers, received words scoreboarded.
module tb_spi_target;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic s0_sclk, s0_cs_n, s0_rx, s0_tx, s0_tx_en;
   logic s3_sclk, s3_cs_n, s3_rx, s3_tx, s3_tx_en;

   spi_target_if #(.WIDTH(8))  f0 ();
   spi_target_if #(.WIDTH(16)) f3 ();

   spi_target #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut0 (
      .clk(clk), .reset(reset), .spi_sclk(s0_sclk), .spi_cs_n(s0_cs_n), .spi_rx(s0_rx),
      .spi_tx(s0_tx), .spi_tx_en(s0_tx_en), .fab(f0)
   );

   spi_target #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut3 (
      .clk(clk), .reset(reset), .spi_sclk(s3_sclk), .spi_cs_n(s3_cs_n), .spi_rx(s3_rx),
      .spi_tx(s3_tx), .spi_tx_en(s3_tx_en), .fab(f3)
   );

   typedef struct {
      logic [7:0] tx;
      logic [7:0] mosi;
      logic [7:0] exp_miso;
      logic [7:0] exp_rx;
   } vec0_t;

   int          n_compared   = 0;
   int          n_mismatched = 0;
   logic [7:0]  sb0 [$];
   logic [15:0] sb3 [$];
   int          rx0_cnt = 0, rx3_cnt = 0, und0 = 0, und3 = 0, abt0 = 0, abt3 = 0;
   int          last_rise0 = 0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard side: pops an expected word whenever a DUT strobes rx_valid.
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         if (f0.rx_valid) begin
            rx0_cnt++;
            if (sb0.size() == 0)
               check_output("rx0_unexpected", 32'(f0.rx_valid), 32'd0);
            else begin
               check_output("rx0_data", 32'(f0.rx_data), 32'(sb0.pop_front()));
               check_output("rx0_latency", 32'(cyc - last_rise0), 32'd3);
            end
         end
         if (f3.rx_valid) begin
            rx3_cnt++;
            if (sb3.size() == 0)
               check_output("rx3_unexpected", 32'(f3.rx_valid), 32'd0);
            else
               check_output("rx3_data", 32'(f3.rx_data), 32'(sb3.pop_front()));
         end
         if (f0.tx_underrun) und0++;
         if (f3.tx_underrun) und3++;
         if (f0.cs_abort) abt0++;
         if (f3.cs_abort) abt3++;
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic push0(input logic [7:0] d);
      for (int t = 0; t < 200 && !f0.tx_ready; t++) @(negedge clk);
      check_output("push0_ready", 32'(f0.tx_ready), 32'd1);
      f0.tx_data  = d;
      f0.tx_valid = 1'b1;
      @(negedge clk);
      f0.tx_valid = 1'b0;
   endtask

   task automatic push3(input logic [15:0] d);
      for (int t = 0; t < 200 && !f3.tx_ready; t++) @(negedge clk);
      check_output("push3_ready", 32'(f3.tx_ready), 32'd1);
      f3.tx_data  = d;
      f3.tx_valid = 1'b1;
      @(negedge clk);
      f3.tx_valid = 1'b0;
   endtask

   // Mode 0 controller: MOSI set while sclk low, MISO read just before the rising edge.
   task automatic spi0_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
      miso = '0;
      for (int i = 0; i < nbits; i++) begin
         s0_rx = mosi[7-i];
         repeat (4) @(negedge clk);
         miso = {miso[6:0], s0_tx};
         s0_sclk    = 1'b1;
         last_rise0 = cyc;
         repeat (4) @(negedge clk);
         s0_sclk = 1'b0;
      end
   endtask

   // Mode 3 controller, LSB first: MOSI changes on the falling edge, MISO read before rising.
   task automatic spi3_word(input logic [15:0] mosi, output logic [15:0] miso);
      miso = '0;
      for (int i = 0; i < 16; i++) begin
         s3_sclk = 1'b0;
         s3_rx   = mosi[i];
         repeat (4) @(negedge clk);
         miso[i] = s3_tx;
         s3_sclk = 1'b1;
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic apply_stimulus(input vec0_t v);
      logic [7:0] miso;
      push0(v.tx);
      check_output("tx_ready_full", 32'(f0.tx_ready), 32'd0);
      s0_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      check_output("tx_ready_after_cs", 32'(f0.tx_ready), 32'd1);
      sb0.push_back(v.exp_rx);
      spi0_bits(v.mosi, 8, miso);
      repeat (4) @(negedge clk);
      s0_cs_n = 1'b1;
      repeat (10) @(negedge clk);
      check_output("miso0_word", 32'(miso), 32'(v.exp_miso));
   endtask

   initial begin
      vec0_t       vecs [4];
      logic [7:0]  m0a, m0b;
      logic [15:0] m3a, m3b;
      int          base_a, base_b, t0;

      vecs[0] = '{tx: 8'h3C, mosi: 8'hA5, exp_miso: 8'h3C, exp_rx: 8'hA5};
      vecs[1] = '{tx: 8'hFF, mosi: 8'h00, exp_miso: 8'hFF, exp_rx: 8'h00};
      vecs[2] = '{tx: 8'h00, mosi: 8'hFF, exp_miso: 8'h00, exp_rx: 8'hFF};
      vecs[3] = '{tx: 8'h81, mosi: 8'h7E, exp_miso: 8'h81, exp_rx: 8'h7E};

      reset = 1'b1;
      s0_sclk = 1'b0; s0_cs_n = 1'b1; s0_rx = 1'b0;
      s3_sclk = 1'b1; s3_cs_n = 1'b1; s3_rx = 1'b0;
      f0.tx_data = '0; f0.tx_valid = 1'b0;
      f3.tx_data = '0; f3.tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_output("rst_tx_ready", 32'(f0.tx_ready), 32'd1);
      check_output("rst_rx_data", 32'(f0.rx_data), 32'd0);
      check_output("rst_rx_valid", 32'(f0.rx_valid), 32'd0);
      check_output("rst_underrun", 32'(f0.tx_underrun), 32'd0);
      check_output("rst_abort", 32'(f0.cs_abort), 32'd0);
      check_output("rst_spi_tx", 32'(s0_tx), 32'd0);
      check_output("rst_rx_data3", 32'(f3.rx_data), 32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check_output("tx_en_idle", 32'(s0_tx_en), 32'd0);

      for (int i = 0; i < 4; i++) apply_stimulus(vecs[i]);

      // Mode 3, 16-bit, LSB first with a filled holding register.
      base_a = und3;
      push3(16'h1234);
      s3_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      sb3.push_back(16'hBEEF);
      spi3_word(16'hBEEF, m3a);
      repeat (4) @(negedge clk);
      s3_cs_n = 1'b1;
      repeat (10) @(negedge clk);
      check_output("miso3_word", 32'(m3a), 32'h1234);
      check_output("und3_none", 32'(und3 - base_a), 32'd0);

      // Two words under one select, holding register filled only for the first.
      base_a = und3;
      base_b = rx3_cnt;
      push3(16'hCAFE);
      s3_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      sb3.push_back(16'h1111);
      sb3.push_back(16'h2222);
      spi3_word(16'h1111, m3a);
      check_output("und3_after_w1", 32'(und3 - base_a), 32'd0);
      spi3_word(16'h2222, m3b);
      repeat (4) @(negedge clk);
      s3_cs_n = 1'b1;
      repeat (10) @(negedge clk);
      check_output("miso3_w1", 32'(m3a), 32'hCAFE);
      check_output("miso3_w2", 32'(m3b), 32'h0000);
      check_output("und3_after_w2", 32'(und3 - base_a), 32'd1);
      check_output("rx3_pulses", 32'(rx3_cnt - base_b), 32'd2);

      // Partial word then deselect, followed by a full transfer.
      base_a = abt0;
      base_b = rx0_cnt;
      s0_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      spi0_bits(8'hFF, 5, m0a);
      repeat (4) @(negedge clk);
      s0_cs_n = 1'b1;
      repeat (10) @(negedge clk);
      check_output("abort_once", 32'(abt0 - base_a), 32'd1);
      check_output("abort_no_rx", 32'(rx0_cnt - base_b), 32'd0);
      s0_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      sb0.push_back(8'h5A);
      spi0_bits(8'h5A, 8, m0a);
      repeat (4) @(negedge clk);
      s0_cs_n = 1'b1;
      repeat (10) @(negedge clk);
      check_output("abort_still_once", 32'(abt0 - base_a), 32'd1);
      check_output("rx_after_abort", 32'(rx0_cnt - base_b), 32'd1);

      // tx_valid held against a full holding register across the load point.
      push0(8'h11);
      f0.tx_data  = 8'h22;
      f0.tx_valid = 1'b1;
      repeat (5) @(negedge clk);
      check_output("hold_full_ready", 32'(f0.tx_ready), 32'd0);
      s0_cs_n = 1'b0;
      t0 = cyc;
      for (int t = 0; t < 20 && !f0.tx_ready; t++) @(negedge clk);
      check_output("ready_return_cycle", 32'(cyc - t0), 32'd3);
      check_output("tx_en_selected", 32'(s0_tx_en), 32'd1);
      @(negedge clk);
      check_output("ready_refilled", 32'(f0.tx_ready), 32'd0);
      f0.tx_valid = 1'b0;
      repeat (4) @(negedge clk);
      sb0.push_back(8'h0F);
      sb0.push_back(8'hF0);
      spi0_bits(8'h0F, 8, m0a);
      spi0_bits(8'hF0, 8, m0b);
      repeat (4) @(negedge clk);
      s0_cs_n = 1'b1;
      repeat (10) @(negedge clk);
      check_output("hold_kept_w1", 32'(m0a), 32'h11);
      check_output("hold_kept_w2", 32'(m0b), 32'h22);

      // Reset in the middle of a word: nothing accepted until select is cycled.
      base_a = rx0_cnt;
      base_b = abt0;
      s0_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      spi0_bits(8'hAA, 3, m0a);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      spi0_bits(8'hAA, 5, m0a);
      repeat (4) @(negedge clk);
      s0_cs_n = 1'b1;
      repeat (10) @(negedge clk);
      check_output("reset_no_rx", 32'(rx0_cnt - base_a), 32'd0);
      check_output("reset_no_abort", 32'(abt0 - base_b), 32'd0);
      s0_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      sb0.push_back(8'hC3);
      spi0_bits(8'hC3, 8, m0a);
      repeat (4) @(negedge clk);
      s0_cs_n = 1'b1;
      repeat (10) @(negedge clk);
      check_output("reset_then_rx", 32'(rx0_cnt - base_a), 32'd1);

      repeat (20) @(negedge clk);
      check_output("sb0_drained", 32'(sb0.size()), 32'd0);
      check_output("sb3_drained", 32'(sb3.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
